// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM state type and its encoding width.
package mult_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH over WIDTH+1 cycles, start/done handshake,
// per-operation signed mode handled by sign-magnitude conditioning around an unsigned core.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] P,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH-1:0] acc_step;

    // Magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned.
    assign a_mag = (is_signed && A[WIDTH-1]) ? -A : A;
    assign b_mag = (is_signed && B[WIDTH-1]) ? -B : B;

    // Lower half of the accumulator carries the shrinking multiplier; its LSB gates the add.
    assign upper_sum = acc_q[0] ? {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q}
                                : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    assign acc_step  = {upper_sum, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        p_d     = p_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mcand_d = a_mag;
                    acc_d   = {{WIDTH{1'b0}}, b_mag};
                    cnt_d   = '0;
                    neg_d   = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                // Result lands on the same edge that enters DONE so P is valid while done is high.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    p_d     = neg_q ? -acc_step : acc_step;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            p_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    assign P    = p_q;
    assign busy = (state_q == ST_RUN);
    assign done = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized and directed checks of seq_multiplier at WIDTH=3 and WIDTH=8 against an arithmetic model.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start3 = 1'b0, sg3 = 1'b0;
    logic [2:0]  a3 = '0, b3 = '0;
    logic [5:0]  p3;
    logic        busy3, done3;

    logic        start8 = 1'b0, sg8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] p8;
    logic        busy8, done8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .is_signed(sg3),
        .A(a3), .B(b3), .P(p3), .busy(busy3), .done(done3)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sg8),
        .A(a8), .B(b8), .P(p8), .busy(busy8), .done(done8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Plain integer product of the operands read in the requested mode, wrapped to 2*w bits.
    function automatic logic [63:0] ref_mul(input int w, input bit sg, input logic [63:0] a,
                                            input logic [63:0] b);
        longint sa, sb;
        sa = (sg && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = (sg && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
        return 64'(sa * sb) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // One WIDTH=3 operation with cycle-exact checks; operands are scrambled during RUN,
    // and poke re-asserts start mid-RUN with different operands.
    task automatic op3(input bit sg, input logic [2:0] a, input logic [2:0] b,
                       input logic [63:0] exp, input bit poke, input string tag);
        @(negedge clk);
        chk({tag, "/idle_busy"}, 64'(busy3), 64'd0);
        chk({tag, "/idle_done"}, 64'(done3), 64'd0);
        start3 = 1'b1; sg3 = sg; a3 = a; b3 = b;
        @(negedge clk);
        start3 = 1'b0; sg3 = 1'($urandom); a3 = 3'($urandom); b3 = 3'($urandom);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "/run_busy"}, 64'(busy3), 64'd1);
            chk({tag, "/run_done"}, 64'(done3), 64'd0);
            @(negedge clk);
            start3 = poke && (i == 0);
            if (poke && i == 0) begin
                a3 = ~a; b3 = ~b;
            end
        end
        start3 = 1'b0;
        chk({tag, "/done"}, 64'(done3), 64'd1);
        chk({tag, "/done_busy"}, 64'(busy3), 64'd0);
        chk({tag, "/P"}, 64'(p3), exp);
    endtask

    task automatic op8(input bit sg, input logic [7:0] a, input logic [7:0] b,
                       input logic [63:0] exp, input string tag);
        int n;
        @(negedge clk);
        start8 = 1'b1; sg8 = sg; a8 = a; b8 = b;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        n = 1;
        while (!done8 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/latency"}, 64'(n), 64'd9);
        chk({tag, "/P"}, 64'(p8), exp);
    endtask

    initial begin
        int seen[$];
        logic [2:0] ra, rb;
        logic [7:0] xa, xb;
        bit         rs;

        #2;
        chk("rst/P3", 64'(p3), 64'd0);
        chk("rst/busy3", 64'(busy3), 64'd0);
        chk("rst/done3", 64'(done3), 64'd0);
        chk("rst/P8", 64'(p8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op3(1'b0, 3'd7, 3'd7, 64'd49, 1'b0, "u7x7");
        op3(1'b1, 3'b100, 3'b100, 64'd16, 1'b0, "sm4xm4");
        op3(1'b1, 3'd3, 3'b110, 64'b111010, 1'b0, "s3xm2");
        op3(1'b0, 3'd5, 3'd3, 64'd15, 1'b1, "ignore_start");
        @(negedge clk);
        chk("ignore_start/single_done", 64'(done3), 64'd0);

        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                for (int s = 0; s < 2; s++)
                    op3(s[0], 3'(a), 3'(b), ref_mul(3, s[0], 64'(a), 64'(b)), 0, "exh");

        for (int i = 0; i < 20; i++) begin
            ra = 3'($urandom); rb = 3'($urandom); rs = 1'($urandom);
            op3(rs, ra, rb, ref_mul(3, rs, 64'(ra), 64'(rb)), 1'($urandom), "rnd3");
        end

        // Back-to-back with start held high: results every 4 cycles.
        @(negedge clk);
        start3 = 1'b1; sg3 = 1'b0; a3 = 3'd5; b3 = 3'd6;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (done3) seen.push_back(i);
            if (i == 3) begin
                chk("b2b/P1", 64'(p3), 64'd30);
                a3 = 3'd2; b3 = 3'd3;
            end
            if (i == 7) begin
                chk("b2b/P2", 64'(p3), 64'd6);
                start3 = 1'b0;
            end
            chk("b2b/excl", 64'(busy3 & done3), 64'd0);
            @(negedge clk);
        end
        chk("b2b/ndone", 64'(seen.size()), 64'd2);
        if (seen.size() == 2) begin
            chk("b2b/t0", 64'(seen[0]), 64'd3);
            chk("b2b/t1", 64'(seen[1]), 64'd7);
        end

        // Asynchronous reset mid-RUN.
        @(negedge clk);
        start3 = 1'b1; sg3 = 1'b0; a3 = 3'd7; b3 = 3'd6;
        @(negedge clk);
        start3 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst/P", 64'(p3), 64'd0);
        chk("mrst/busy", 64'(busy3), 64'd0);
        chk("mrst/done", 64'(done3), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mrst/no_done", 64'(done3), 64'd0);
            chk("mrst/no_busy", 64'(busy3), 64'd0);
        end
        op3(1'b1, 3'd3, 3'd3, 64'd9, 1'b0, "after_rst");

        op8(1'b0, 8'd255, 8'd255, 64'd65025, "u255x255");
        op8(1'b1, 8'h80, 8'h80, 64'd16384, "sm128xm128");
        op8(1'b1, 8'h80, 8'h7f, ref_mul(8, 1'b1, 64'h80, 64'h7f), "sm128x127");
        for (int i = 0; i < 16; i++) begin
            xa = 8'($urandom); xb = 8'($urandom); rs = 1'($urandom);
            op8(rs, xa, xb, ref_mul(8, rs, 64'(xa), 64'(xb)), "rnd8");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
